bf_key_loader: RTL and testbench
================================

// Module: bf_key_loader
// PURPOSE
//  Upstream key stage for bf_encryption: accepts a variable-length Blowfish user key (1..14 x 32-bit
//  words) over a valid/ready stream. Builds the 18-entry P-array as P[i] = PINIT[i] ^ key[i mod len].
//  Presents the result on a flat bus that drives k1..k18 of the combinational cipher core.
//  S-box re-keying is out of scope: the round function uses fixed S-boxes, so only the P-array is produced.
// PARAMETERS
//  MAX_KEY_WORDS  14  maximum key length in 32-bit words (448 bits); key_len above this is rejected
//  NUM_P          18  P-array entries; fixed by the cipher, not to be overridden
// PORTS
//  clk        in   1    single clock; all state on rising edge
//  rst_n      in   1    synchronous reset, active low
//  start      in   1    request new key load; sampled only in IDLE
//  key_len    in   4    key length in words, sampled with start; legal 1..14
//  key_word   in   32   key word, first word = most significant 32 bits of the user key
//  key_valid  in   1    key_word valid
//  key_ready  out  1    block accepts key_word (high only in LOAD)
//  busy       out  1    high in LOAD and MIX
//  err        out  1    one-cycle pulse: start with illegal key_len
//  p_valid    out  1    p_array holds a complete schedule (high in DONE)
//  p_array    out  576  P-array, P1 (k1) at [31:0] ... P18 (k18) at [575:544]
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE, all outputs 0, key buffer and p_array cleared to 0,
//    counters 0. Applies from any state, including mid-LOAD/MIX; the partial schedule is discarded.
//  - FSM states IDLE, LOAD, MIX, DONE:
//    IDLE: start & key_len in 1..14 -> latch len, word count=0, go LOAD.
//          start & illegal key_len (0 or 15) -> err=1 for one cycle, stay IDLE.
//    LOAD: key_ready=1. Each key_valid&key_ready edge writes key_buf[cnt] and increments cnt.
//          The edge accepting word len-1 moves to MIX with i=0, j=0. Gaps in key_valid are allowed.
//    MIX: one entry per cycle: p_array[i] <= PINIT[i] ^ key_buf[j]; i++.
//         j wraps to 0 when j==len-1. After i==17 is written, go DONE. key_ready=0 throughout.
//    DONE: p_valid=1, p_array held stable. start in DONE is treated as in IDLE (legal -> LOAD, p_valid drops the
//          next cycle; illegal -> err pulse, stay DONE with p_valid kept 1).
//  - start while busy: ignored, no err. key_valid outside LOAD: ignored.
//  - Latency: p_valid rises at the 19th rising edge after the edge accepting the final key word
//    (18 MIX cycles + DONE entry). p_array is not guaranteed stable while busy.
//  - Arithmetic: plain 32-bit XOR, no carries. cnt 0..13, i 0..17, j 0..len-1 (4-5 bit counters).
//  - len=14 wrap: P15..P18 reuse key words 0..3. len=1: every P entry XORed with the same word.
//  - PINIT (hex) P1..P18: 243F6A88 85A308D3 13198A2E 03707344 A4093822 299F31D0 082EFA98 EC4E6C89
//    452821E6 38D01377 BE5466CF 34E90C6C C0AC29B7 C97C50DD 3F84D5B5 B5470917 9216D5D9 8979FB1B
// STRUCTURE
//  - Shared package bf_pkg: PINIT constant table (18 x 32), NUM_P, MAX_KEY_WORDS, FSM state encoding.
//  - Single module; no sub-module needed (key buffer is a 14x32 register file, mix is one XOR per cycle).
// TESTING
//  1 len=1, key 00000000 -> after 19 edges p_valid=1, p_array equals PINIT exactly (P1=243F6A88).
//  2 len=1, key FFFFFFFF -> P1=DBC09577, P18=768604E4; all entries = ~PINIT.
//  3 len=14, words 00000001..0000000E -> P14=C97C50D3, P15=3F84D5B4 (wraps to word 0), P18=8979FB1F.
//  4 start with key_len=0, then 15 -> err pulses one cycle each, key_ready stays 0, p_valid unchanged.
//  5 len=4 with key_valid gaps of 3 cycles -> same p_array as gapless load; key_ready low after 4th word.
//  6 rst_n=0 during MIX cycle 9 -> next cycle IDLE, p_array=0, p_valid=0; start again completes normally.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared constants for the Blowfish key stage: P-array initial values,
// array sizes and the key loader state encoding.
package bf_pkg;

    localparam int NUM_P         = 18;
    localparam int MAX_KEY_WORDS = 14;
    localparam int WORD_W        = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Fractional hex digits of pi, P1..P18
    function automatic logic [31:0] pinit_word(input logic [4:0] idx);
        logic [31:0] w;
        case (idx)
            5'd0:    w = 32'h243F_6A88;
            5'd1:    w = 32'h85A3_08D3;
            5'd2:    w = 32'h1319_8A2E;
            5'd3:    w = 32'h0370_7344;
            5'd4:    w = 32'hA409_3822;
            5'd5:    w = 32'h299F_31D0;
            5'd6:    w = 32'h082E_FA98;
            5'd7:    w = 32'hEC4E_6C89;
            5'd8:    w = 32'h4528_21E6;
            5'd9:    w = 32'h38D0_1377;
            5'd10:   w = 32'hBE54_66CF;
            5'd11:   w = 32'h34E9_0C6C;
            5'd12:   w = 32'hC0AC_29B7;
            5'd13:   w = 32'hC97C_50DD;
            5'd14:   w = 32'h3F84_D5B5;
            5'd15:   w = 32'hB547_0917;
            5'd16:   w = 32'h9216_D5D9;
            5'd17:   w = 32'h8979_FB1B;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic key_len_legal(input logic [3:0] len);
        return (len != 4'd0) && (len <= 4'(MAX_KEY_WORDS));
    endfunction

endpackage

// File: rtl/bf_key_loader.sv
// Blowfish key stage: streams in a 1..14 word user key and builds the
// 18-entry P-array (PINIT xor cyclically repeated key) one entry per cycle.
module bf_key_loader
    import bf_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                key_len,
    input  logic [31:0]               key_word,
    input  logic                      key_valid,
    output logic                      key_ready,
    output logic                      busy,
    output logic                      err,
    output logic                      p_valid,
    output logic [NUM_P*WORD_W-1:0]   p_array
);

    state_e      state_q, state_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  i_q, i_d;
    logic [3:0]  j_q, j_d;
    logic        err_q, err_d;
    logic        p_valid_q, p_valid_d;
    logic [31:0] key_buf_q [MAX_KEY_WORDS];
    logic [31:0] key_buf_d [MAX_KEY_WORDS];
    logic [31:0] p_q [NUM_P];
    logic [31:0] p_d [NUM_P];
    logic        key_ready_s;
    logic        busy_s;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= 4'd0;
            cnt_q     <= 4'd0;
            i_q       <= 5'd0;
            j_q       <= 4'd0;
            err_q     <= 1'b0;
            p_valid_q <= 1'b0;
            key_buf_q <= '{default: 32'h0000_0000};
            p_q       <= '{default: 32'h0000_0000};
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            err_q     <= err_d;
            p_valid_q <= p_valid_d;
            key_buf_q <= key_buf_d;
            p_q       <= p_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        err_d     = 1'b0;
        key_buf_d = key_buf_q;
        p_d       = p_q;
        // Lags DONE by one edge so the schedule is announced one cycle after the last write
        p_valid_d = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (key_len_legal(key_len)) begin
                        len_d   = key_len;
                        cnt_d   = 4'd0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (key_valid) begin
                    key_buf_d[cnt_q] = key_word;
                    cnt_d            = cnt_q + 4'd1;
                    if (cnt_q == (len_q - 4'd1)) begin
                        i_d     = 5'd0;
                        j_d     = 4'd0;
                        state_d = S_MIX;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_MIX: begin
                p_d[i_q] = pinit_word(i_q) ^ key_buf_q[j_q];
                if (j_q == (len_q - 4'd1)) begin
                    j_d = 4'd0;
                end else begin
                    j_d = j_q + 4'd1;
                end
                if (i_q == 5'(NUM_P - 1)) begin
                    state_d = S_DONE;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and status decode from the state register
    always_comb begin
        key_ready_s = 1'b0;
        busy_s      = 1'b0;
        case (state_q)
            S_LOAD: begin
                key_ready_s = 1'b1;
                busy_s      = 1'b1;
            end
            S_MIX: begin
                busy_s = 1'b1;
            end
            default: begin
                key_ready_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Flatten P-array, P1 in the low word
    always_comb begin
        p_array = '0;
        for (int k = 0; k < NUM_P; k++) begin
            p_array[k*WORD_W +: WORD_W] = p_q[k];
        end
    end

    assign key_ready = key_ready_s;
    assign busy      = busy_s;
    assign err       = err_q;
    assign p_valid   = p_valid_q;

endmodule

// File: tb/tb_bf_key_loader.sv
// Scoreboarded bench for bf_key_loader: random and directed key loads checked
// against a plain-arithmetic P-array model, plus error, gap and reset scenarios.
module tb_bf_key_loader;

    typedef logic [31:0] key_t [14];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   key_len;
    logic [31:0]  key_word;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         err;
    logic         p_valid;
    logic [575:0] p_array;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    int           edge_cnt = 0;
    logic [575:0] exp_q [$];
    int           acc_q [$];
    logic         pv_prev = 1'b0;

    logic [31:0] pinit_t [18] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822, 32'h299F31D0,
        32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917, 32'h9216D5D9, 32'h8979FB1B};

    bf_key_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_len   (key_len),
        .key_word  (key_word),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .err       (err),
        .p_valid   (p_valid),
        .p_array   (p_array)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [575:0] model(input key_t k, input int len);
        logic [575:0] r;
        for (int i = 0; i < 18; i++) r[i*32 +: 32] = pinit_t[i] ^ k[i % len];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every rising p_valid must match the oldest pending schedule
    always @(negedge clk) begin
        logic [575:0] e;
        int a;
        if (p_valid && !pv_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_p_valid: got p_valid=1 expected no pending schedule");
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("p_array", p_array, e);
                chk("latency", 576'(edge_cnt - a), 576'(19));
            end
        end
        pv_prev <= p_valid;
    end

    task automatic load(input int len, input key_t k, input int gap, input bit junk_start,
                        output int acc);
        @(negedge clk);
        start   = 1'b1;
        key_len = 4'(len);
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < len; w++) begin
            key_valid = 1'b1;
            key_word  = k[w];
            if (junk_start && w == 0) begin
                start   = 1'b1;
                key_len = 4'($urandom_range(0, 15));
            end
            chk("key_ready_in_load", 576'(key_ready), 576'(1));
            acc = edge_cnt + 1;
            @(negedge clk);
            start     = 1'b0;
            key_valid = 1'b0;
            key_word  = $urandom;
            if (w == len - 1) chk("key_ready_after_last", 576'(key_ready), 576'(0));
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!p_valid && n < 40) begin
            key_valid = 1'($urandom_range(0, 1));
            key_word  = $urandom;
            @(negedge clk);
            n++;
        end
        key_valid = 1'b0;
        if (!p_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got p_valid=0 expected 1 within 40 cycles");
        end
    endtask

    task automatic illegal_start(input logic [3:0] len, input logic pv_exp);
        @(negedge clk);
        start   = 1'b1;
        key_len = len;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 576'(err), 576'(1));
        chk("err_key_ready", 576'(key_ready), 576'(0));
        chk("err_p_valid", 576'(p_valid), 576'(pv_exp));
        @(negedge clk);
        chk("err_clear", 576'(err), 576'(0));
        chk("err_busy", 576'(busy), 576'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        key_t k;
        int   acc;
        rst_n = 1'b0; start = 1'b0; key_len = 4'd0; key_word = 32'd0; key_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_p_valid", 576'(p_valid), 576'(0));
        chk("rst_busy", 576'(busy), 576'(0));
        chk("rst_key_ready", 576'(key_ready), 576'(0));
        chk("rst_err", 576'(err), 576'(0));
        chk("rst_p_array", p_array, 576'(0));
        rst_n = 1'b1;

        // len=1, all-zero key
        k = '{default: 32'h0};
        load(1, k, 0, 1'b0, acc);
        exp_q.push_back(model(k, 1)); acc_q.push_back(acc);
        wait_done();
        chk("zero_key_p1", 576'(p_array[31:0]), 576'(32'h243F6A88));

        // len=1, all-ones key
        k = '{default: 32'hFFFFFFFF};
        load(1, k, 0, 1'b0, acc);
        exp_q.push_back(model(k, 1)); acc_q.push_back(acc);
        wait_done();
        chk("ones_key_p1", 576'(p_array[31:0]), 576'(32'hDBC09577));
        chk("ones_key_p18", 576'(p_array[575:544]), 576'(32'h768604E4));

        // len=14, counting words
        for (int w = 0; w < 14; w++) k[w] = 32'(w + 1);
        load(14, k, 0, 1'b0, acc);
        exp_q.push_back(model(k, 14)); acc_q.push_back(acc);
        wait_done();
        chk("len14_p14", 576'(p_array[447:416]), 576'(32'hC97C50D3));
        chk("len14_p15", 576'(p_array[479:448]), 576'(32'h3F84D5B4));
        chk("len14_p18", 576'(p_array[575:544]), 576'(32'h8979FB1F));

        // illegal lengths from DONE keep p_valid
        illegal_start(4'd0, 1'b1);
        illegal_start(4'd15, 1'b1);

        // len=4, gapped and gapless loads of the same key
        for (int w = 0; w < 14; w++) k[w] = $urandom;
        load(4, k, 3, 1'b0, acc);
        exp_q.push_back(model(k, 4)); acc_q.push_back(acc);
        wait_done();
        load(4, k, 0, 1'b0, acc);
        exp_q.push_back(model(k, 4)); acc_q.push_back(acc);
        wait_done();

        // reset during MIX cycle 9 discards the schedule
        for (int w = 0; w < 14; w++) k[w] = $urandom;
        load(3, k, 0, 1'b0, acc);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mixrst_p_valid", 576'(p_valid), 576'(0));
        chk("mixrst_busy", 576'(busy), 576'(0));
        chk("mixrst_p_array", p_array, 576'(0));
        rst_n = 1'b1;
        illegal_start(4'd0, 1'b0);
        load(3, k, 0, 1'b0, acc);
        exp_q.push_back(model(k, 3)); acc_q.push_back(acc);
        wait_done();

        // randomized loads with ignored mid-load starts and key_valid noise
        for (int t = 0; t < 24; t++) begin
            int len;
            len = $urandom_range(1, 14);
            for (int w = 0; w < 14; w++) k[w] = $urandom;
            if ($urandom_range(0, 3) == 0) illegal_start(4'($urandom_range(0, 1) * 15), 1'b1);
            load(len, k, $urandom_range(0, 2), 1'($urandom_range(0, 1)), acc);
            exp_q.push_back(model(k, len)); acc_q.push_back(acc);
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 576'(exp_q.size()), 576'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
